// File: rtl/defines_pkg.sv
// Shared riscy pipeline definitions: datapath width, writeback FSM states,
// load funct3 encodings, opcode and instruction types.
package defines;

   localparam int XLEN = 32;

   // Architectural zero register, never written.
   localparam logic [4:0] NULL = 5'd0;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      opcode_t    opcode;
   } instr_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: extracts the byte/half/word/dword at the byte
// offset, sign- or zero-extends it, and flags misaligned or illegal loads.
module load_align import defines::*; #(
   parameter int XLEN = defines::XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   localparam bit IS64 = (XLEN == 64);

   logic [2:0]      off_eff;
   logic [XLEN-1:0] shifted;

   // On a 32-bit datapath only the low two address bits select a byte.
   assign off_eff = IS64 ? off : {1'b0, off[1:0]};
   assign shifted = mem_rdata >> {off_eff, 3'b000};

   always_comb begin
      data     = '0;
      misalign = 1'b0;
      case (funct3)
         F3_LB:  data = XLEN'($signed(shifted[7:0]));
         F3_LBU: data = XLEN'(shifted[7:0]);
         F3_LH: begin
            data     = XLEN'($signed(shifted[15:0]));
            misalign = off_eff[0];
         end
         F3_LHU: begin
            data     = XLEN'(shifted[15:0]);
            misalign = off_eff[0];
         end
         F3_LW: begin
            data     = XLEN'($signed(shifted[31:0]));
            misalign = (off_eff[1:0] != 2'b00);
         end
         F3_LWU: begin
            data     = XLEN'(shifted[31:0]);
            misalign = !IS64 || (off_eff[1:0] != 2'b00);
         end
         F3_LD: begin
            data     = shifted;
            misalign = !IS64 || (off_eff != 3'b000);
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: per-opcode source select, load alignment and a
// timed wait for memory responses. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_stage import defines::*; #(
   parameter int XLEN         = defines::XLEN,
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  instr_t          instr,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] pc_p4,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            retire,
   output logic            wb_err
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0]     retire_cnt
`endif
);

   localparam int CNT_W = $clog2(LOAD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_TIMEOUT - 1);

   wb_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       ld_rd_q, ld_rd_d;
   logic [2:0]       ld_f3_q, ld_f3_d;
   logic [2:0]       ld_off_q, ld_off_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
   logic             retire_q, retire_d;
   logic             wb_err_q, wb_err_d;

   logic             waiting;
   logic [2:0]       la_f3;
   logic [2:0]       la_off;
   logic [XLEN-1:0]  la_data;
   logic             la_misalign;
   logic             wr;
   logic [4:0]       wr_rd;
   logic [XLEN-1:0]  wr_data;
   logic             unused_instr;

   assign unused_instr = ^{instr.funct7, instr.rs2, instr.rs1};

   assign waiting  = (state_q == WAIT_MEM);
   assign in_ready = (state_q == IDLE) && !rst;

   // The aligner sees the live instruction in IDLE and the latched load in WAIT_MEM.
   assign la_f3  = waiting ? ld_f3_q  : instr.funct3;
   assign la_off = waiting ? ld_off_q : alu_result[2:0];

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3    (la_f3),
      .off       (la_off),
      .mem_rdata (mem_rdata),
      .data      (la_data),
      .misalign  (la_misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ld_rd_q    <= '0;
         ld_f3_q    <= '0;
         ld_off_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         retire_q   <= 1'b0;
         wb_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_rd_q    <= ld_rd_d;
         ld_f3_q    <= ld_f3_d;
         ld_off_q   <= ld_off_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         retire_q   <= retire_d;
         wb_err_q   <= wb_err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_rd_d  = ld_rd_q;
      ld_f3_d  = ld_f3_q;
      ld_off_d = ld_off_q;
      case (state_q)
         IDLE: begin
            if (in_valid && instr.opcode == OPC_LOAD && !la_misalign && !mem_rvalid) begin
               state_d  = WAIT_MEM;
               cnt_d    = '0;
               ld_rd_d  = instr.rd;
               ld_f3_d  = instr.funct3;
               ld_off_d = alu_result[2:0];
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid || cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr       = 1'b0;
      retire_d = 1'b0;
      wb_err_d = 1'b0;
      wr_rd    = instr.rd;
      wr_data  = alu_result;
      if (waiting) begin
         wr_rd   = ld_rd_q;
         wr_data = la_data;
         if (mem_rvalid) begin
            wr       = 1'b1;
            retire_d = 1'b1;
         end else if (cnt_q == CNT_MAX) begin
            wb_err_d = 1'b1;
         end
      end else if (in_valid) begin
         case (instr.opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
               wr       = 1'b1;
               retire_d = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
               wr       = 1'b1;
               retire_d = 1'b1;
               wr_data  = pc_p4;
            end
            OPC_BRANCH, OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM: retire_d = 1'b1;
            OPC_LOAD: begin
               if (la_misalign) begin
                  wb_err_d = 1'b1;
               end else if (mem_rvalid) begin
                  wr       = 1'b1;
                  retire_d = 1'b1;
                  wr_data  = la_data;
               end
            end
            default: wb_err_d = 1'b1;
         endcase
      end
      rf_we_d    = wr && (wr_rd != NULL);
      rf_waddr_d = rf_we_d ? wr_rd   : rf_waddr_q;
      rf_wdata_d = rf_we_d ? wr_data : rf_wdata_q;
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign retire   = retire_q;
   assign wb_err   = wb_err_q;

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt_q, retire_cnt_d;

   // Advances together with the retire pulse; wraps naturally at 2^64.
   always_comb begin
      retire_cnt_d = retire_cnt_q + {63'd0, retire_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=32, LOAD_TIMEOUT=16).
module tb_wb_stage;
   import defines::*;

   localparam int XL = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   instr_t        instr = '0;
   logic [XL-1:0] alu_result = '0;
   logic [XL-1:0] pc_p4 = '0;
   logic          mem_rvalid = 1'b0;
   logic [XL-1:0] mem_rdata = '0;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [XL-1:0] rf_wdata;
   logic          retire;
   logic          wb_err;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0]   retire_cnt;
`endif

   int checks = 0;
   int errors = 0;

   wb_stage #(.XLEN(XL), .LOAD_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr      (instr),
      .alu_result (alu_result),
      .pc_p4      (pc_p4),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .retire     (retire),
      .wb_err     (wb_err)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic ret, input logic err);
      chk({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, we});
      chk({tag, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, wa});
      chk({tag, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, wd});
      chk({tag, ".retire"}, {63'd0, retire}, {63'd0, ret});
      chk({tag, ".wb_err"}, {63'd0, wb_err}, {63'd0, err});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input opcode_t op, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [31:0] alu);
      instr        = '0;
      instr.opcode = op;
      instr.rd     = rd;
      instr.funct3 = f3;
      alu_result   = alu;
      in_valid     = 1'b1;
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("reset.in_ready", {63'd0, in_ready}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
      chk("reset.retire_cnt", retire_cnt, 64'd0);
`endif
      step();
      step();
      rst = 1'b0;
      #1;
      chk("idle.in_ready", {63'd0, in_ready}, 64'd1);

      drv(OPC_OP_IMM, 5'd5, 3'b000, 32'h1234);
      step();
      chk_out("addi", 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);

      drv(OPC_JAL, 5'd1, 3'b000, 32'h0);
      pc_p4 = 32'h104;
      step();
      chk_out("jal", 1'b1, 5'd1, 32'h104, 1'b1, 1'b0);

      drv(OPC_JAL, 5'd0, 3'b000, 32'h0);
      pc_p4 = 32'h208;
      step();
      chk_out("jal_x0", 1'b0, 5'd1, 32'h104, 1'b1, 1'b0);

      drv(OPC_LOAD, 5'd7, F3_LB, 32'h1003);
      mem_rdata  = 32'h80FF_FFFF;
      mem_rvalid = 1'b1;
      step();
      chk_out("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0);

      drv(OPC_LOAD, 5'd8, F3_LBU, 32'h1003);
      step();
      chk_out("lbu", 1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0);

      drv(OPC_LOAD, 5'd2, F3_LHU, 32'h0002);
      mem_rdata = 32'h8001_0000;
      step();
      chk_out("lhu", 1'b1, 5'd2, 32'h0000_8001, 1'b1, 1'b0);

      drv(OPC_LOAD, 5'd3, F3_LH, 32'h0002);
      step();
      chk_out("lh", 1'b1, 5'd3, 32'hFFFF_8001, 1'b1, 1'b0);

      in_valid = 1'b0;
      step();
      chk_out("bubble", 1'b0, 5'd3, 32'hFFFF_8001, 1'b0, 1'b0);

      // rvalid in IDLE without an accepted load is ignored
      mem_rvalid = 1'b0;
      drv(OPC_LOAD, 5'd9, F3_LW, 32'h2000);
      step();
      in_valid = 1'b0;
      chk("lw_wait1.in_ready", {63'd0, in_ready}, 64'd0);
      chk_out("lw_wait1", 1'b0, 5'd3, 32'hFFFF_8001, 1'b0, 1'b0);
      step();
      chk("lw_wait2.in_ready", {63'd0, in_ready}, 64'd0);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("lw_wait3.in_ready", {63'd0, in_ready}, 64'd0);
      step();
      mem_rvalid = 1'b0;
      chk_out("lw_late", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
      chk("lw_late.in_ready", {63'd0, in_ready}, 64'd1);

      drv(OPC_LOAD, 5'd10, F3_LW, 32'h3000);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("timeout_pre.wb_err", {63'd0, wb_err}, 64'd0);
         chk("timeout_pre.in_ready", {63'd0, in_ready}, 64'd0);
      end
      step();
      chk_out("timeout", 1'b0, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1);
      chk("timeout.in_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk("timeout_pulse.wb_err", {63'd0, wb_err}, 64'd0);

      // rvalid on the final counter cycle wins over the timeout
      drv(OPC_LOAD, 5'd11, F3_LW, 32'h3004);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 15; i++) step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_55AA;
      step();
      mem_rvalid = 1'b0;
      chk_out("rvalid_at_limit", 1'b1, 5'd11, 32'h0000_55AA, 1'b1, 1'b0);

      drv(OPC_LOAD, 5'd12, F3_LW, 32'h4000);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      #1;
      chk_out("rst_in_wait", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("rst_in_wait.in_ready", {63'd0, in_ready}, 64'd0);
      mem_rvalid = 1'b1;
      step();
      rst        = 1'b0;
      mem_rvalid = 1'b0;
      step();
      chk_out("after_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("after_rst.in_ready", {63'd0, in_ready}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
      chk("after_rst.retire_cnt", retire_cnt, 64'd0);
`endif

      for (int i = 0; i < 10; i++) begin
         drv(OPC_OP_IMM, 5'(i + 1), 3'b000, 32'h100 + i);
         step();
         chk_out("addi_burst", 1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 1'b0);
      end
      in_valid = 1'b0;
      step();
`ifdef WB_RETIRE_CNT_EN
      chk("burst.retire_cnt", retire_cnt, 64'd10);
`endif

      drv(OPC_LOAD, 5'd13, F3_LH, 32'h1001);
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      in_valid   = 1'b0;
      chk_out("lh_misalign", 1'b0, 5'd10, 32'h109, 1'b0, 1'b1);
      chk("lh_misalign.in_ready", {63'd0, in_ready}, 64'd1);

      drv(OPC_LOAD, 5'd14, F3_LW, 32'h1002);
      step();
      in_valid = 1'b0;
      chk_out("lw_misalign", 1'b0, 5'd10, 32'h109, 1'b0, 1'b1);
      chk("lw_misalign.in_ready", {63'd0, in_ready}, 64'd1);

      instr      = instr_t'(32'h0000_0F7F);
      in_valid   = 1'b1;
      step();
      chk_out("bad_opcode", 1'b0, 5'd10, 32'h109, 1'b0, 1'b1);

      drv(OPC_STORE, 5'd6, 3'b010, 32'h5000);
      step();
      chk_out("store", 1'b0, 5'd10, 32'h109, 1'b1, 1'b0);

      drv(OPC_LUI, 5'd4, 3'b000, 32'hABCD_E000);
      step();
      in_valid = 1'b0;
      chk_out("lui", 1'b1, 5'd4, 32'hABCD_E000, 1'b1, 1'b0);
      step();
`ifdef WB_RETIRE_CNT_EN
      chk("final.retire_cnt", retire_cnt, 64'd12);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
